regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Shares the single write port of a multi-read-port register file among `num_req` requesters with round-robin arbitration and a one-cycle registered write stage. It sits directly in front of the register file's `ADDR_IN`/`D_IN`/`WE` pins; the read ports are untouched. Optionally, after reset it sweeps every entry `lo..hi` to a known value before accepting traffic. Addresses outside `lo..hi` are flagged and dropped.

## Interface
- `addr_width`, 5: register-file address width.
- `data_width`, 64: register-file data width.
- `num_req`, 4: number of write requesters (≥2).
- `lo`, 0: lowest valid register-file index.
- `hi`, 31: highest valid register-file index.
- `init_value`, 0: value written by the post-reset sweep (`data_width` bits).

- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST_N`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  num_req  write request per requester.
- `req_addr`  in  num_req*addr_width  target index; requester i occupies bits `[i*addr_width +: addr_width]`.
- `req_data`  in  num_req*data_width  write data; requester i occupies bits `[i*data_width +: data_width]`.
- `req_ready`  out  num_req  one-hot grant; a request is accepted when `req_valid[i] & req_ready[i]`.
- `rf_addr_in`  out  addr_width  drives register-file `ADDR_IN`.
- `rf_d_in`  out  data_width  drives register-file `D_IN`.
- `rf_we`  out  1  drives register-file `WE`.
- `busy`  out  1  high while the init sweep is running.
- `err_oob`  out  1  sticky flag: an out-of-range address was accepted.

## Operation
- States: `INIT` (only if the sweep is compiled in) and `RUN`.
  - Reset enters `INIT`, or `RUN` if the sweep is compiled out.
- **INIT:**
  - One write per cycle of `init_value`. A sweep counter walks `lo` up to `hi`.
  - `req_ready` is all zero.
  - After the write to `hi` is issued, the next state is `RUN`.
- **RUN arbitration:**
  - A round-robin pointer `ptr` resets to 0.
  - The grant goes to the first requester with `req_valid` high, searching from `ptr` upward and wrapping modulo `num_req`.
  - `req_ready` is combinational from `req_valid` and `ptr`: at most one bit is set, and none if no request is valid.
  - On acceptance by requester g, `ptr` becomes `(g+1) mod num_req`. With no acceptance, `ptr` holds.
- **Write stage:**
  - The accepted address and data are registered.
  - The next cycle `rf_we`=1 with `rf_addr_in`/`rf_d_in` equal to the accepted values.
  - Throughput is one write per cycle. Back-to-back grants are allowed.
- **Out-of-range address** (`addr < lo` or `addr > hi`, compared unsigned):
  - The request is still granted and consumed.
  - `rf_we` stays 0 for that slot.
  - `err_oob` is set and stays set until reset.
- No read/write bypass is provided. Readers see new data the cycle after `rf_we`, matching the register-file write timing.

## Timing
- **Reset values:**
  - `rf_we`=0, `rf_addr_in`=0, `rf_d_in`=0, `err_oob`=0, `ptr`=0.
  - `busy`=1 with the sweep compiled in, 0 without.
  - `req_ready` follows the state: 0 in `INIT`; combinational from inputs in `RUN`.
- **Accept-to-write latency:** accept in cycle N gives `rf_we`=1 in cycle N+1; the entry holds the new data from cycle N+2.
- **Init sweep:**
  - Lasts `hi-lo+1` cycles after `RST_N` deasserts, one write per cycle.
  - `busy` falls in the cycle after the final sweep write, which is the first `RUN` cycle.
  - The first grant is possible in that same cycle.
- **Reset mid-operation:**
  - `RST_N` low clears all state immediately, including a pending write: `rf_we` drops asynchronously.
  - The sweep restarts from `lo`.
- **Simultaneous requests** are resolved by the pointer only. A requester that holds `req_valid` waits at most `num_req-1` grants.

## Configuration
- `REGFILE_ARB_INIT_EN` defined:
  - The `INIT` state and sweep counter are built.
  - `busy` is as described above.
- Not defined:
  - The block resets directly into `RUN`.
  - `busy` is tied to 0.
  - No sweep writes are issued; register-file contents after reset are whatever the register file itself provides.

## Test plan
- **Init sweep** (`REGFILE_ARB_INIT_EN` defined, lo=0, hi=31, init_value=0): release reset → 32 consecutive writes to addresses 0..31 with data 0, `busy` falls on cycle 32, and all reads return 0.
- **Full contention:** all 4 requesters hold valid continuously from `ptr`=0 → grant order is 0,1,2,3,0,…, `rf_we` is high every cycle, and each `rf_d_in` matches its grantee's data one cycle after acceptance.
- **Sparse requests:** only requesters 1 and 3 valid, `ptr`=2 → grant 3 then 1; `ptr` ends at 2.
- **Out-of-range address:** lo=0, hi=23, requester 0 writes address 30 with data 0xDEAD → `req_ready[0]`=1, `rf_we` stays 0 the next cycle, `err_oob`=1 and stays 1 for later legal writes.
- **Reset mid-sweep:** assert `RST_N` low at sweep address 10 → `rf_we` drops immediately; after release the sweep restarts at address 0 and `busy` is high for 32 cycles.
- **Write then read:** write 0x1234 to address 5 → `D_OUT` for address 5 reads 0x1234 from accept cycle +2.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter and registered write stage in front of a register-file write port.
// Define REGFILE_ARB_INIT_EN to build the post-reset sweep that writes init_value to lo..hi.
module regfile_write_arbiter #(
    parameter int unsigned           addr_width = 5,
    parameter int unsigned           data_width = 64,
    parameter int unsigned           num_req    = 4,
    parameter int                    lo         = 0,
    parameter int                    hi         = 31,
    parameter logic [data_width-1:0] init_value = '0
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic [num_req-1:0]            req_valid,
    input  logic [num_req*addr_width-1:0] req_addr,
    input  logic [num_req*data_width-1:0] req_data,
    output logic [num_req-1:0]            req_ready,
    output logic [addr_width-1:0]         rf_addr_in,
    output logic [data_width-1:0]         rf_d_in,
    output logic                          rf_we,
    output logic                          busy,
    output logic                          err_oob
);
    localparam int unsigned PTR_W = $clog2(num_req);

    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic                  we_q, we_d;
    logic [addr_width-1:0] addr_q, addr_d;
    logic [data_width-1:0] data_q, data_d;
    logic                  err_q, err_d;

    logic                  run;
    logic                  gnt_any;
    logic [PTR_W-1:0]      gnt_idx;
    logic [PTR_W-1:0]      idx;
    logic [addr_width-1:0] sel_addr;
    logic [data_width-1:0] sel_data;
    logic                  sel_in_range;
    logic                  accept;

`ifdef REGFILE_ARB_INIT_EN
    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t                state_q, state_d;
    logic [addr_width-1:0] sweep_q, sweep_d;

    assign run  = (state_q == ST_RUN);
    assign busy = (state_q == ST_INIT);
`else
    logic unused_init;

    assign run         = 1'b1;
    assign busy        = 1'b0;
    assign unused_init = ^init_value;
`endif

    // Walk from ptr upward with wrap; first valid requester wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = ptr_q;
        for (int unsigned k = 0; k < num_req; k++) begin
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx;
            end
            idx = (idx == PTR_W'(num_req - 1)) ? '0 : idx + PTR_W'(1);
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned k = 0; k < num_req; k++) begin
            if (gnt_idx == PTR_W'(k)) begin
                sel_addr = req_addr[k*addr_width +: addr_width];
                sel_data = req_data[k*data_width +: data_width];
            end
        end
    end

    assign sel_in_range = (int'(sel_addr) >= lo) && (int'(sel_addr) <= hi);
    assign accept       = run && gnt_any;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d  = ptr_q;
        we_d   = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        err_d  = err_q;
`ifdef REGFILE_ARB_INIT_EN
        state_d = state_q;
        sweep_d = sweep_q;
        if (state_q == ST_INIT) begin
            we_d   = 1'b1;
            addr_d = sweep_q;
            data_d = init_value;
            if (sweep_q == addr_width'(hi)) begin
                state_d = ST_RUN;
            end else begin
                sweep_d = sweep_q + addr_width'(1);
            end
        end else
`endif
        if (accept) begin
            ptr_d = (gnt_idx == PTR_W'(num_req - 1)) ? '0 : gnt_idx + PTR_W'(1);
            // Out-of-range requests are consumed but never reach the register file.
            if (sel_in_range) begin
                we_d   = 1'b1;
                addr_d = sel_addr;
                data_d = sel_data;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ptr_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
`ifdef REGFILE_ARB_INIT_EN
            state_q <= ST_INIT;
            sweep_q <= addr_width'(lo);
`endif
        end else begin
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
`ifdef REGFILE_ARB_INIT_EN
            state_q <= state_d;
            sweep_q <= sweep_d;
`endif
        end
    end

    assign rf_we      = we_q;
    assign rf_addr_in = addr_q;
    assign rf_d_in    = data_q;
    assign err_oob    = err_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized lockstep bench for regfile_write_arbiter against a cycle-level behavioural model.
module tb_regfile_write_arbiter;
    localparam int AW = 5;
    localparam int DW = 64;
    localparam int N  = 4;
    localparam int LO = 2;
    localparam int HI = 27;
    localparam logic [DW-1:0] INITV = 64'hA5A5_0F0F_3C3C_9696;
`ifdef REGFILE_ARB_INIT_EN
    localparam bit HAS_INIT = 1'b1;
`else
    localparam bit HAS_INIT = 1'b0;
`endif

    logic              CLK = 1'b0;
    logic              RST_N;
    logic [N-1:0]      req_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic [AW-1:0]     rf_addr_in;
    logic [DW-1:0]     rf_d_in;
    logic              rf_we;
    logic              busy;
    logic              err_oob;

    always #5 CLK = ~CLK;

    regfile_write_arbiter #(
        .addr_width(AW),
        .data_width(DW),
        .num_req   (N),
        .lo        (LO),
        .hi        (HI),
        .init_value(INITV)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rf_addr_in(rf_addr_in),
        .rf_d_in   (rf_d_in),
        .rf_we     (rf_we),
        .busy      (busy),
        .err_oob   (err_oob)
    );

    // Register file fed by the DUT outputs.
    logic [DW-1:0] rf [0:31];
    always @(posedge CLK) begin
        if (rf_we) rf[rf_addr_in] <= rf_d_in;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model state
    int            m_ptr;
    bit            m_init;
    int            m_sweep;
    bit            e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    bit            e_err;
    logic [DW-1:0] mrf [0:31];
    bit            mrf_set [0:31];

    bit [N-1:0]    s_valid;
    logic [AW-1:0] s_addr [N];
    logic [DW-1:0] s_data [N];
    int            last_g;

    task automatic model_reset();
        m_ptr   = 0;
        m_init  = HAS_INIT;
        m_sweep = LO;
        e_we    = 1'b0;
        e_addr  = '0;
        e_data  = '0;
        e_err   = 1'b0;
    endtask

    function automatic int model_grant();
        for (int k = 0; k < N; k++) begin
            if (s_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]           = s_valid[i];
            req_addr[i*AW +: AW]   = s_addr[i];
            req_data[i*DW +: DW]   = s_data[i];
        end
    endtask

    // One clock: starts and ends at a falling edge.
    task automatic cycle();
        int g;
        logic [63:0] exp_ready;
        drive();
        #1;
        g = m_init ? -1 : model_grant();
        exp_ready = (g < 0) ? 64'd0 : (64'd1 << g);
        chk("ready", {60'd0, req_ready}, exp_ready);
        last_g = g;
        if (m_init) begin
            e_we   = 1'b1;
            e_addr = AW'(m_sweep);
            e_data = INITV;
            if (m_sweep == HI) m_init = 1'b0;
            else m_sweep++;
        end else if (g >= 0) begin
            m_ptr = (g + 1) % N;
            if (int'(s_addr[g]) >= LO && int'(s_addr[g]) <= HI) begin
                e_we   = 1'b1;
                e_addr = s_addr[g];
                e_data = s_data[g];
            end else begin
                e_we  = 1'b0;
                e_err = 1'b1;
            end
        end else begin
            e_we = 1'b0;
        end
        if (e_we) begin
            mrf[e_addr]     = e_data;
            mrf_set[e_addr] = 1'b1;
        end
        @(posedge CLK);
        #1;
        chk("we", {63'd0, rf_we}, {63'd0, e_we});
        if (e_we) begin
            chk("addr", {59'd0, rf_addr_in}, {59'd0, e_addr});
            chk("data", rf_d_in, e_data);
        end
        chk("busy", {63'd0, busy}, {63'd0, m_init});
        chk("err", {63'd0, err_oob}, {63'd0, e_err});
        @(negedge CLK);
    endtask

    task automatic randomize_inputs(input int oob_ok);
        s_valid = N'($urandom);
        for (int i = 0; i < N; i++) begin
            s_addr[i] = oob_ok ? AW'($urandom_range(0, 31)) : AW'($urandom_range(LO, HI));
            s_data[i] = {$urandom, $urandom};
        end
    endtask

    task automatic run_sweep(input string tag);
        int n;
        n = 0;
        while (busy && n < 100) begin
            randomize_inputs(1);
            cycle();
            n++;
        end
        chk(tag, 64'(n), HAS_INIT ? 64'(HI - LO + 1) : 64'd0);
    endtask

    // Asserts reset between clock edges; starts and ends at a falling edge.
    task automatic mid_reset();
        #2 RST_N = 1'b0;
        #1;
        chk("rst_we", {63'd0, rf_we}, 64'd0);
        chk("rst_addr", {59'd0, rf_addr_in}, 64'd0);
        chk("rst_err", {63'd0, err_oob}, 64'd0);
        chk("rst_busy", {63'd0, busy}, {63'd0, HAS_INIT});
        @(negedge CLK);
        chk("rst_hold_we", {63'd0, rf_we}, 64'd0);
        RST_N = 1'b1;
        model_reset();
    endtask

    initial begin
        for (int a = 0; a < 32; a++) mrf_set[a] = 1'b0;
        RST_N   = 1'b1;
        s_valid = '1;
        for (int i = 0; i < N; i++) begin
            s_addr[i] = AW'(LO + i);
            s_data[i] = '0;
        end
        drive();
        #1 RST_N = 1'b0;
        #2;
        chk("reset_we", {63'd0, rf_we}, 64'd0);
        chk("reset_addr", {59'd0, rf_addr_in}, 64'd0);
        chk("reset_data", rf_d_in, 64'd0);
        chk("reset_err", {63'd0, err_oob}, 64'd0);
        chk("reset_busy", {63'd0, busy}, {63'd0, HAS_INIT});
        chk("reset_ready", {60'd0, req_ready}, HAS_INIT ? 64'd0 : 64'd1);
        @(negedge CLK);
        RST_N = 1'b1;
        model_reset();
        s_valid = '0;

        run_sweep("sweep_len");

        // Full contention from ptr 0
        s_valid = '1;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < N; i++) begin
                s_addr[i] = AW'(LO + 4 * i + (c % 4));
                s_data[i] = {$urandom, $urandom};
            end
            cycle();
            chk("cont_order", 64'(last_g), 64'(c % 4));
            chk("cont_we", {63'd0, rf_we}, 64'd1);
        end

        // Sparse: move ptr to 2, then requesters 1 and 3 only
        s_valid = 4'b0010;
        cycle();
        s_valid = 4'b1010;
        cycle();
        chk("sparse_first", 64'(last_g), 64'd3);
        cycle();
        chk("sparse_second", 64'(last_g), 64'd1);
        s_valid = 4'b1111;
        cycle();
        chk("sparse_ptr", 64'(last_g), 64'd2);

        // Out-of-range address, then a legal write read back
        s_valid   = 4'b0001;
        s_addr[0] = 5'd30;
        s_data[0] = 64'hDEAD;
        cycle();
        chk("oob_grant", 64'(last_g), 64'd0);
        chk("oob_we", {63'd0, rf_we}, 64'd0);
        chk("oob_err", {63'd0, err_oob}, 64'd1);
        s_valid   = 4'b0100;
        s_addr[2] = 5'd5;
        s_data[2] = 64'h1234;
        cycle();
        s_valid = '0;
        cycle();
        chk("rd5", rf[5], 64'h1234);
        chk("err_sticky", {63'd0, err_oob}, 64'd1);

        for (int c = 0; c < 400; c++) begin
            randomize_inputs(1);
            cycle();
        end

        // Reset while a write is pending
        mid_reset();
        if (HAS_INIT) begin
            for (int c = 0; c <= 10 - LO; c++) begin
                randomize_inputs(1);
                cycle();
            end
        end else begin
            s_valid   = 4'b0100;
            s_addr[2] = 5'd10;
            s_data[2] = {$urandom, $urandom};
            cycle();
        end
        chk("pre_rst_we", {63'd0, rf_we}, 64'd1);
        chk("pre_rst_addr", {59'd0, rf_addr_in}, 64'd10);
        mid_reset();
        run_sweep("resweep_len");

        for (int c = 0; c < 200; c++) begin
            randomize_inputs(1);
            cycle();
        end
        s_valid = '0;
        cycle();
        cycle();

        for (int a = 0; a < 32; a++) begin
            if (mrf_set[a]) chk("rf_content", rf[a], mrf[a]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule
